// File: rtl/mem_port_sched_pkg.sv
// Shared definitions for the memory-port scheduler: funct3 element modes,
// element sizing, load extension and the FSM state type.
package mem_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Illegal modes fall through to 4 so they still walk at word stride.
    function automatic logic [2:0] elem_size(input logic [2:0] mode);
        case (mode)
            FUNCT3_B, FUNCT3_BU: elem_size = 3'd1;
            FUNCT3_H, FUNCT3_HU: elem_size = 3'd2;
            default:             elem_size = 3'd4;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [2:0] mode);
        mode_legal = (mode == FUNCT3_B)  || (mode == FUNCT3_H)  || (mode == FUNCT3_W) ||
                     (mode == FUNCT3_BU) || (mode == FUNCT3_HU);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] mode);
        case (mode)
            FUNCT3_B:  load_extend = {{24{raw[7]}}, raw[7:0]};
            FUNCT3_H:  load_extend = {{16{raw[15]}}, raw[15:0]};
            FUNCT3_W:  load_extend = raw;
            FUNCT3_BU: load_extend = {24'b0, raw[7:0]};
            FUNCT3_HU: load_extend = {16'b0, raw[15:0]};
            default:   load_extend = 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// Bundle of the two requester ports, the response ports and the memory
// load/store port seen by mem_port_sched.
interface mem_port_sched_if #(
    parameter int BEATS_W = 4,
    parameter int ADDR_W  = 32
);
    logic               req_valid0, req_valid1;
    logic               req_ready0, req_ready1;
    logic [ADDR_W-1:0]  req_addr0, req_addr1;
    logic               req_write0, req_write1;
    logic [2:0]         req_mode0, req_mode1;
    logic [BEATS_W-1:0] req_beats0, req_beats1;
    logic [31:0]        req_wdata0, req_wdata1;
    logic [BEATS_W-1:0] beat_idx;
    logic               rsp_valid0, rsp_valid1;
    logic [31:0]        rsp_rdata0, rsp_rdata1;
    logic               rsp_last0, rsp_last1;
    logic [ADDR_W-1:0]  mem_address;
    logic [31:0]        mem_write;
    logic               mem_is_read, mem_is_write;
    logic [2:0]         mem_mode;
    logic [31:0]        mem_read;

    modport master (
        output req_valid0, req_valid1, req_addr0, req_addr1, req_write0, req_write1,
               req_mode0, req_mode1, req_beats0, req_beats1, req_wdata0, req_wdata1,
               mem_read,
        input  req_ready0, req_ready1, beat_idx, rsp_valid0, rsp_valid1,
               rsp_rdata0, rsp_rdata1, rsp_last0, rsp_last1,
               mem_address, mem_write, mem_is_read, mem_is_write, mem_mode
    );

    modport slave (
        input  req_valid0, req_valid1, req_addr0, req_addr1, req_write0, req_write1,
               req_mode0, req_mode1, req_beats0, req_beats1, req_wdata0, req_wdata1,
               mem_read,
        output req_ready0, req_ready1, beat_idx, rsp_valid0, rsp_valid1,
               rsp_rdata0, rsp_rdata1, rsp_last0, rsp_last1,
               mem_address, mem_write, mem_is_read, mem_is_write, mem_mode
    );
endinterface

// File: rtl/mem_port_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie
// and moves to the loser on every grant.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic grant_en,
    output logic gnt0,
    output logic gnt1
);
    logic ptr_reg;

    assign gnt0 = grant_en && valid0 && (!valid1 || !ptr_reg);
    assign gnt1 = grant_en && valid1 && (!valid0 ||  ptr_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (gnt0 || gnt1) begin
            ptr_reg <= gnt0;
        end
    end
endmodule

// File: rtl/mem_port_sched.sv
// Shares the memory load/store port between a scalar and a vector LSU,
// expanding each accepted request into strided element beats.
module mem_port_sched
    import mem_pkg::*;
#(
    parameter int BEATS_W = 4,
    parameter int ADDR_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_port_sched_if.slave bus
);
    state_t             state_reg;
    logic               owner_reg;
    logic               write_reg;
    logic [2:0]         mode_reg;
    logic [BEATS_W-1:0] beat_cnt_reg;
    logic [BEATS_W-1:0] last_idx_reg;
    logic [ADDR_W-1:0]  addr_reg;

    logic               gnt0, gnt1, grant_en, busy, legal, last_beat;
    logic [BEATS_W-1:0] req_beats_sel;
    logic [31:0]        beat_rdata;

    // Gating with rst keeps ready low for the whole reset, not just after the edge.
    assign grant_en = (state_reg == IDLE) && !rst;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid0   (bus.req_valid0),
        .valid1   (bus.req_valid1),
        .grant_en (grant_en),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    assign bus.req_ready0 = gnt0;
    assign bus.req_ready1 = gnt1;

    assign busy          = (state_reg == BUSY);
    assign legal         = mode_legal(mode_reg);
    assign last_beat     = (beat_cnt_reg == last_idx_reg);
    assign req_beats_sel = gnt1 ? bus.req_beats1 : bus.req_beats0;
    assign beat_rdata    = write_reg ? 32'b0 : load_extend(bus.mem_read, mode_reg);

    assign bus.mem_address  = busy ? addr_reg : '0;
    assign bus.mem_write    = busy ? (owner_reg ? bus.req_wdata1 : bus.req_wdata0) : 32'b0;
    assign bus.mem_is_read  = busy && legal && !write_reg;
    assign bus.mem_is_write = busy && legal &&  write_reg;
    assign bus.mem_mode     = busy ? mode_reg : 3'b0;
    assign bus.beat_idx     = busy ? beat_cnt_reg : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            write_reg    <= 1'b0;
            mode_reg     <= 3'b0;
            beat_cnt_reg <= '0;
            last_idx_reg <= '0;
            addr_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner_reg    <= gnt1;
                        addr_reg     <= gnt1 ? bus.req_addr1  : bus.req_addr0;
                        write_reg    <= gnt1 ? bus.req_write1 : bus.req_write0;
                        mode_reg     <= gnt1 ? bus.req_mode1  : bus.req_mode0;
                        // A zero beat count is a single-beat request.
                        last_idx_reg <= (req_beats_sel == '0) ? '0 : req_beats_sel - BEATS_W'(1);
                        beat_cnt_reg <= '0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    addr_reg     <= addr_reg + ADDR_W'(elem_size(mode_reg));
                    beat_cnt_reg <= beat_cnt_reg + BEATS_W'(1);
                    if (last_beat) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-port response registers; only the owner sees a beat.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic        valid_reg;
        logic        last_reg;
        logic [31:0] rdata_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                last_reg  <= 1'b0;
                rdata_reg <= 32'b0;
            end else if (busy && (owner_reg == 1'(gi))) begin
                valid_reg <= 1'b1;
                last_reg  <= last_beat;
                rdata_reg <= beat_rdata;
            end else begin
                valid_reg <= 1'b0;
                last_reg  <= 1'b0;
                rdata_reg <= 32'b0;
            end
        end
    end

    assign bus.rsp_valid0 = g_rsp[0].valid_reg;
    assign bus.rsp_valid1 = g_rsp[1].valid_reg;
    assign bus.rsp_last0  = g_rsp[0].last_reg;
    assign bus.rsp_last1  = g_rsp[1].last_reg;
    assign bus.rsp_rdata0 = g_rsp[0].rdata_reg;
    assign bus.rsp_rdata1 = g_rsp[1].rdata_reg;
endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: a response scoreboard fed at each
// handshake, a word-memory model, and per-beat checks of the memory port.
module tb_mem_port_sched;
    localparam logic [2:0] M_B = 3'b000, M_H = 3'b001, M_W = 3'b010;
    localparam logic [2:0] M_BU = 3'b100, M_HU = 3'b101, M_BAD = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          last;
        int          cyc;
    } rsp_t;
    rsp_t sb[$];

    mem_port_sched_if #(.BEATS_W(4), .ADDR_W(32)) bus ();

    mem_port_sched #(.BEATS_W(4), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h1122_3344;
        return {a[7:0] ^ 8'h96, a[7:0] ^ 8'h3C, a[7:0] + 8'h80, a[7:0] ^ 8'hE5};
    endfunction

    function automatic bit tb_legal(input logic [2:0] m);
        return (m == M_B) || (m == M_H) || (m == M_W) || (m == M_BU) || (m == M_HU);
    endfunction

    function automatic logic [31:0] tb_size(input logic [2:0] m);
        if (m == M_B || m == M_BU) return 32'd1;
        if (m == M_H || m == M_HU) return 32'd2;
        return 32'd4;
    endfunction

    function automatic logic [31:0] tb_ext(input logic [31:0] w, input logic [2:0] m);
        logic signed [31:0] s;
        s = $signed(w);
        case (m)
            M_B:     return 32'(($signed(s <<< 24)) >>> 24);
            M_H:     return 32'(($signed(s <<< 16)) >>> 16);
            M_BU:    return w & 32'h0000_00FF;
            M_HU:    return w & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    function automatic logic rdy(input bit p);
        return p ? bus.req_ready1 : bus.req_ready0;
    endfunction

    always_comb bus.mem_read = mem_fn(bus.mem_address);
    assign bus.req_wdata0 = 32'h0000_C000 + 32'(bus.beat_idx);
    assign bus.req_wdata1 = 32'h0000_00A0 + 32'(bus.beat_idx);

    // Response monitor: every presented beat must match the head of the scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && (bus.rsp_valid0 || bus.rsp_valid1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {30'b0, bus.rsp_valid1, bus.rsp_valid0}, 32'b0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", {30'b0, bus.rsp_valid1, bus.rsp_valid0}, e.port ? 32'd2 : 32'd1);
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_rdata", e.port ? bus.rsp_rdata1 : bus.rsp_rdata0, e.rdata);
                chk("rsp_last", {31'b0, e.port ? bus.rsp_last1 : bus.rsp_last0}, {31'b0, e.last});
            end
        end
    end

    task automatic set_req(input bit p, input logic [31:0] a, input bit wr,
                           input logic [2:0] m, input logic [3:0] b);
        if (p) begin
            bus.req_addr1 = a; bus.req_write1 = wr; bus.req_mode1 = m;
            bus.req_beats1 = b; bus.req_valid1 = 1'b1;
        end else begin
            bus.req_addr0 = a; bus.req_write0 = wr; bus.req_mode0 = m;
            bus.req_beats0 = b; bus.req_valid0 = 1'b1;
        end
    endtask

    // Handshake on port p, queue expected responses, then check every issued beat
    // and the IDLE cycle that follows. Returns at that IDLE cycle's falling edge.
    task automatic run_txn(input bit p, input logic [31:0] a, input bit wr,
                           input logic [2:0] m, input logic [3:0] b);
        int n, c, nb;
        logic [31:0] ak;
        bit lg;
        n = 0;
        #1;
        while (!rdy(p) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("grant", {31'b0, rdy(p)}, 32'd1);
        @(posedge clk);
        c  = cyc;
        nb = (b == 0) ? 1 : int'(b);
        lg = tb_legal(m);
        for (int k = 0; k < nb; k++) begin
            ak = a + 32'(k) * tb_size(m);
            sb.push_back('{p, (lg && !wr) ? tb_ext(mem_fn(ak), m) : 32'b0, k == nb - 1, c + 2 + k});
        end
        #1;
        if (p) bus.req_valid1 = 1'b0; else bus.req_valid0 = 1'b0;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            ak = a + 32'(k) * tb_size(m);
            chk("beat_addr", bus.mem_address, ak);
            chk("beat_is_read", {31'b0, bus.mem_is_read}, {31'b0, lg && !wr});
            chk("beat_is_write", {31'b0, bus.mem_is_write}, {31'b0, lg && wr});
            chk("beat_mode", {29'b0, bus.mem_mode}, {29'b0, m});
            chk("beat_idx", {28'b0, bus.beat_idx}, 32'(k));
            if (wr) chk("beat_wdata", bus.mem_write, (p ? 32'h0000_00A0 : 32'h0000_C000) + 32'(k));
            chk("ready_while_busy", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd0);
        end
        @(negedge clk);
        chk("idle_strobes", {30'b0, bus.mem_is_read, bus.mem_is_write}, 32'd0);
        chk("idle_addr", bus.mem_address, 32'd0);
        chk("idle_wdata", bus.mem_write, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        bus.req_valid0 = 1'b0; bus.req_valid1 = 1'b0;
        set_req(0, 32'h0, 1'b0, M_W, 4'd1);
        set_req(1, 32'h0, 1'b0, M_W, 4'd1);

        // Reset state: requests present, yet nothing may be driven.
        repeat (2) @(negedge clk);
        chk("rst_ready", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd0);
        chk("rst_rsp", {30'b0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);
        chk("rst_mem", {30'b0, bus.mem_is_read, bus.mem_is_write}, 32'd0);
        chk("rst_addr", bus.mem_address, 32'd0);
        chk("rst_beat_idx", {28'b0, bus.beat_idx}, 32'd0);
        bus.req_valid0 = 1'b0; bus.req_valid1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Single scalar load.
        set_req(0, 32'h10, 1'b0, M_W, 4'd1);
        run_txn(0, 32'h10, 1'b0, M_W, 4'd1);

        // Vector halfword store, three beats.
        set_req(1, 32'h20, 1'b1, M_H, 4'd3);
        run_txn(1, 32'h20, 1'b1, M_H, 4'd3);

        // Contention: port 0 first, port 1 in the IDLE cycle after, port 0 again.
        set_req(0, 32'h40, 1'b0, M_W, 4'd1);
        set_req(1, 32'h53, 1'b0, M_BU, 4'd1);
        #1 chk("arb_first", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd1);
        run_txn(0, 32'h40, 1'b0, M_W, 4'd1);
        #1 chk("arb_back_to_back", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd2);
        run_txn(1, 32'h53, 1'b0, M_BU, 4'd1);
        set_req(0, 32'h62, 1'b0, M_H, 4'd2);
        set_req(1, 32'h70, 1'b0, M_HU, 4'd1);
        #1 chk("arb_third", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd1);
        run_txn(0, 32'h62, 1'b0, M_H, 4'd2);
        bus.req_valid1 = 1'b0;
        #1 chk("drop_valid", {31'b0, bus.req_ready1}, 32'd0);
        @(negedge clk);

        // Zero beats at the top of memory, then a word burst wrapping through 0.
        set_req(1, 32'hFFFF_FFFF, 1'b0, M_B, 4'd0);
        run_txn(1, 32'hFFFF_FFFF, 1'b0, M_B, 4'd0);
        set_req(0, 32'hFFFF_FFFC, 1'b0, M_W, 4'd2);
        run_txn(0, 32'hFFFF_FFFC, 1'b0, M_W, 4'd2);

        // Illegal mode: sequenced at word stride, strobes low, zero data.
        set_req(1, 32'h80, 1'b0, M_BAD, 4'd2);
        run_txn(1, 32'h80, 1'b0, M_BAD, 4'd2);

        // Reset during beat 2 of a 5-beat load: only beats 0 and 1 respond.
        set_req(0, 32'h100, 1'b0, M_W, 4'd5);
        #1 chk("mid_grant", {31'b0, bus.req_ready0}, 32'd1);
        @(posedge clk);
        c = cyc;
        sb.push_back('{1'b0, mem_fn(32'h100), 1'b0, c + 2});
        sb.push_back('{1'b0, mem_fn(32'h104), 1'b0, c + 3});
        #1 bus.req_valid0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_beat1_addr", bus.mem_address, 32'h104);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rsp", {30'b0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);
        chk("mid_rst_mem", {30'b0, bus.mem_is_read, bus.mem_is_write}, 32'd0);
        chk("mid_rst_addr", bus.mem_address, 32'd0);
        chk("mid_rst_beat_idx", {28'b0, bus.beat_idx}, 32'd0);
        set_req(0, 32'h200, 1'b0, M_W, 4'd1);
        set_req(1, 32'h300, 1'b0, M_W, 4'd1);
        #1 chk("mid_rst_ready", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("ptr_after_rst", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd1);
        bus.req_valid1 = 1'b0;
        run_txn(0, 32'h200, 1'b0, M_W, 4'd1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
